y86_regfile_sb: RTL and testbench
=================================

# y86_regfile_sb

Parametrised Y86-64 register file with two combinational read ports, two synchronous write ports (E and M), and a per-register pending-write scoreboard. It is the next-generation decode/write-back store for the pipelined core. Decode reads `srcA`/`srcB` and reserves destinations. Write-back retires `dstE`/`dstM`. Scoreboard hazards are reported to the pipeline controller as stall requests.

## Interface
Parameters:
- `XLEN`, 64: register data width.
- `NREGS`, 15: number of architectural registers. Valid range is 2..15.
- `AW`, 4: register address width. Address `4'hF` (`RNONE`) means "no register".
- `SP_RESET`, 64'd254: reset value of register 4 (`%rsp`). All other registers reset to 0.
- `PEND_MAX`, 3: maximum outstanding claims per register.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, **asynchronous and active-low**.
- `srcA`, `srcB` in AW: read addresses.
- `valA`, `valB` out XLEN: read data. Both read 0 when the address is `RNONE` or ≥ NREGS.
- `busyA`, `busyB` out 1: the addressed register has pending claims > 0 (after any same-cycle retire).
- `stall` out 1: `busyA | busyB | ~claim_ready`.
- `claim_valid` in 1: reserve `claim_dstE` and `claim_dstM` this cycle.
- `claim_dstE`, `claim_dstM` in AW: destinations to reserve. `RNONE` means no reservation.
- `claim_ready` out 1: no addressed claim destination is at PEND_MAX.
- `dstE` in AW, `valE` in XLEN: E write port.
- `dstM` in AW, `valM` in XLEN: M write port.
- `regs_flat` out NREGS*XLEN: all registers for debug. Register i occupies bits [i*XLEN +: XLEN].

## Operation
- **Reads:** combinational from array state.
- **Writes:**
  - On `posedge clk`, `dstE != RNONE` writes `valE` and `dstM != RNONE` writes `valM`.
  - Addresses ≥ NREGS are ignored.
  - If `dstE == dstM`, M wins. This gives Y86 `popq %rsp` semantics: `%rsp` takes `valM`.
- **Scoreboard:** one saturating counter `pend[i]` per register, 0..PEND_MAX.
  - An accepted claim on register i is `claim_valid & claim_ready` with i equal to `claim_dstE` or `claim_dstM`. It adds +1.
  - A retire on register i is a write with `dstE == i` or `dstM == i`. It adds -1.
  - Claim and retire on the same register in the same cycle: counter unchanged.
  - `claim_dstE == claim_dstM` counts as one claim. `dstE == dstM` counts as one retire.
  - Retire with `pend == 0`: the write still occurs and the counter stays 0. It never underflows.
  - Claim with `claim_ready` low: no counter changes for either destination, and `stall` is high.
- **Reset:** asserting `rst_n` low at any time, including mid-operation:
  - all registers go to 0, except reg 4, which goes to `SP_RESET`;
  - all `pend` counters go to 0.
  - Outputs during reset: `valA`/`valB` reflect the reset state, `busyA`/`busyB` = 0, `claim_ready` = 1, `stall` = 0.

## Timing
- Read latency is 0 cycles (combinational). Written data is visible on reads the cycle after the write edge.
- `busyA`/`busyB` and `claim_ready` are combinational from counters and current-cycle inputs.
- A claim takes effect at the edge. A read of that register the next cycle sees `busy` = 1.
- Reset release is synchronous-safe. The first write is accepted at the first rising edge after `rst_n` goes high.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- **Defined:**
  - A read whose address matches a same-cycle `dstM` returns `valM`.
  - Otherwise, a read whose address matches a same-cycle `dstE` returns `valE`.
  - A matching retire also removes that register's contribution to `busyA`/`busyB` when it brings `pend` to 0.
- **Undefined:** reads return array contents only. `busy` reflects the counter before the edge, so a register being retired still shows busy that cycle.

## Structure
- Shared package `y86_pkg`: `RNONE` (4'hF), `RRSP` (4'd4), icode constants, and the `reg_addr_t` typedef. `y86_regfile_sb` imports it.
- One sub-module, `pend_counter`: a saturating up/down counter with `inc`, `dec`, `at_max` and `nonzero` outputs, and asynchronous active-low reset. It is instantiated NREGS times via generate.

## Test plan
- Reset check: hold `rst_n` low, then release.
  - `regs_flat` reg 4 = 254; all other registers = 0.
  - `stall` = 0 and `claim_ready` = 1.
- Same-port collision: `dstE` = `dstM` = 4, `valE` = 246, `valM` = 77 → next cycle, `srcA` = 4 gives `valA` = 77.
- Claim then read: claim `claim_dstE` = 2; next cycle, `srcA` = 2 → `busyA` = 1 and `stall` = 1.
  - Write `dstE` = 2, `valE` = 9.
  - With `REGFILE_BYPASS_EN`: same cycle `valA` = 9 and `busyA` = 0.
  - Without it: next cycle `valA` = 9 and `busyA` = 0.
- Saturation: three claims on reg 3 → `claim_ready` = 0 when a fourth is presented.
  - The fourth claim is rejected and `pend` stays at 3.
  - A claim and a retire on reg 3 in the same cycle leave `pend` at 3.
- Underflow: retire `dstE` = 5, `valE` = 11 with `pend` = 0 → reg 5 = 11, `pend[5]` = 0, `busy` never asserts.
- Reset mid-flight: pend reg 6 = 2 and reg 6 = 40, then pulse `rst_n` low between edges → reg 6 = 0 and `busyB` (`srcB` = 6) = 0 immediately.

Source files
------------

// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module   : y86_pkg
// Purpose  : Shared Y86-64 constants: register ids, icodes, address type.
// Revision : 1.0 - initial release
// ============================================================================
package y86_pkg;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'd4;

    localparam logic [3:0] c_I_HALT   = 4'h0;
    localparam logic [3:0] c_I_NOP    = 4'h1;
    localparam logic [3:0] c_I_RRMOVQ = 4'h2;
    localparam logic [3:0] c_I_IRMOVQ = 4'h3;
    localparam logic [3:0] c_I_RMMOVQ = 4'h4;
    localparam logic [3:0] c_I_MRMOVQ = 4'h5;
    localparam logic [3:0] c_I_OPQ    = 4'h6;
    localparam logic [3:0] c_I_JXX    = 4'h7;
    localparam logic [3:0] c_I_CALL   = 4'h8;
    localparam logic [3:0] c_I_RET    = 4'h9;
    localparam logic [3:0] c_I_PUSHQ  = 4'hA;
    localparam logic [3:0] c_I_POPQ   = 4'hB;

    typedef logic [3:0] reg_addr_t;

endpackage
`default_nettype wire

// File: rtl/pend_counter.sv
`default_nettype none
// ============================================================================
// Module   : pend_counter
// Purpose  : Saturating up/down pending-write counter, 0..PEND_MAX.
// Revision : 1.0 - initial release
// ============================================================================
module pend_counter #(
    parameter int PEND_MAX = 3,
    parameter int CW       = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          at_max,
    output logic          nonzero
);

    logic [CW-1:0] r_count;
    logic          w_at_max;
    logic          w_nonzero;

    assign w_at_max  = (r_count == CW'(PEND_MAX));
    assign w_nonzero = (r_count != '0);

    // Simultaneous inc and dec cancel; dec at zero is dropped so it never underflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && !dec && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end else if (dec && !inc && w_nonzero) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count   = r_count;
    assign at_max  = w_at_max;
    assign nonzero = w_nonzero;

endmodule
`default_nettype wire

// File: rtl/y86_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : y86_regfile_sb
// Purpose  : Y86-64 register file, 2 read / 2 write ports, pending-write
//            scoreboard. Optional same-cycle bypass: REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module y86_regfile_sb
    import y86_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter int              NREGS    = 15,
    parameter int              AW       = 4,
    parameter logic [XLEN-1:0] SP_RESET = XLEN'(254),
    parameter int              PEND_MAX = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AW-1:0]         srcA,
    input  logic [AW-1:0]         srcB,
    output logic [XLEN-1:0]       valA,
    output logic [XLEN-1:0]       valB,
    output logic                  busyA,
    output logic                  busyB,
    output logic                  stall,
    input  logic                  claim_valid,
    input  logic [AW-1:0]         claim_dstE,
    input  logic [AW-1:0]         claim_dstM,
    output logic                  claim_ready,
    input  logic [AW-1:0]         dstE,
    input  logic [XLEN-1:0]       valE,
    input  logic [AW-1:0]         dstM,
    input  logic [XLEN-1:0]       valM,
    output logic [NREGS*XLEN-1:0] regs_flat
);

    localparam int c_CW = $clog2(PEND_MAX + 1);
`ifdef REGFILE_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [c_CW-1:0]  w_count [NREGS];
    logic [NREGS-1:0] w_inc;
    logic [NREGS-1:0] w_dec;
    logic [NREGS-1:0] w_block;
    logic [NREGS-1:0] w_at_max;
    logic [NREGS-1:0] w_nonzero;
    logic [NREGS-1:0] w_clear;
    logic             w_claim_ready;

    // A register retiring this cycle frees a slot, so it does not block a claim.
    assign w_claim_ready = ~|w_block;

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        localparam logic [XLEN-1:0] c_RST_VAL = (i == int'(RRSP)) ? SP_RESET : '0;
        logic w_claim_hit;

        assign w_claim_hit = (claim_dstE == AW'(i)) || (claim_dstM == AW'(i));
        assign w_dec[i]    = (dstE == AW'(i)) || (dstM == AW'(i));
        assign w_block[i]  = claim_valid & w_claim_hit & w_at_max[i] & ~w_dec[i];
        assign w_inc[i]    = claim_valid & w_claim_ready & w_claim_hit;
        assign w_clear[i]  = w_dec[i] & ~w_inc[i] & (w_count[i] == c_CW'(1));

        pend_counter #(
            .PEND_MAX (PEND_MAX),
            .CW       (c_CW)
        ) u_pend (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (w_inc[i]),
            .dec     (w_dec[i]),
            .count   (w_count[i]),
            .at_max  (w_at_max[i]),
            .nonzero (w_nonzero[i])
        );

        // M has priority so popq %rsp leaves the popped value in %rsp.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_regs[i] <= c_RST_VAL;
            end else if (dstM == AW'(i)) begin
                r_regs[i] <= valM;
            end else if (dstE == AW'(i)) begin
                r_regs[i] <= valE;
            end
        end

        assign regs_flat[i*XLEN +: XLEN] = r_regs[i];
    end

    always_comb begin
        valA  = '0;
        busyA = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (srcA == AW'(i)) begin
                valA  = r_regs[i];
                busyA = w_nonzero[i] & ~(c_BYPASS & w_clear[i]);
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (int'(srcA) < NREGS) begin
            if (srcA == dstM) begin
                valA = valM;
            end else if (srcA == dstE) begin
                valA = valE;
            end
        end
`endif
    end

    always_comb begin
        valB  = '0;
        busyB = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (srcB == AW'(i)) begin
                valB  = r_regs[i];
                busyB = w_nonzero[i] & ~(c_BYPASS & w_clear[i]);
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (int'(srcB) < NREGS) begin
            if (srcB == dstM) begin
                valB = valM;
            end else if (srcB == dstE) begin
                valB = valE;
            end
        end
`endif
    end

    assign claim_ready = w_claim_ready;
    assign stall       = busyA | busyB | ~w_claim_ready;

endmodule
`default_nettype wire

// File: tb/tb_y86_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_y86_regfile_sb
// Purpose  : Scoreboard-driven self-checking bench for y86_regfile_sb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_y86_regfile_sb;

    localparam int XLEN  = 64;
    localparam int NREGS = 15;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [3:0]            srcA, srcB, claim_dstE, claim_dstM, dstE, dstM;
    logic [XLEN-1:0]       valE, valM, valA, valB;
    logic                  busyA, busyB, stall, claim_valid, claim_ready;
    logic [NREGS*XLEN-1:0] regs_flat;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } sb_entry_t;
    sb_entry_t sb_q[$];

    y86_regfile_sb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .srcA        (srcA),
        .srcB        (srcB),
        .valA        (valA),
        .valB        (valB),
        .busyA       (busyA),
        .busyB       (busyB),
        .stall       (stall),
        .claim_valid (claim_valid),
        .claim_dstE  (claim_dstE),
        .claim_dstM  (claim_dstM),
        .claim_ready (claim_ready),
        .dstE        (dstE),
        .valE        (valE),
        .dstM        (dstM),
        .valM        (valM),
        .regs_flat   (regs_flat)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] exp);
        sb_q.push_back('{tag: tag, exp: exp});
    endtask

    task automatic sb_pop(input logic [63:0] obs);
        sb_entry_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_underrun", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, obs, e.exp);
        end
    endtask

    task automatic idle();
        srcA = 4'hF; srcB = 4'hF;
        claim_valid = 1'b0; claim_dstE = 4'hF; claim_dstM = 4'hF;
        dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] reg_at(input int i);
        return regs_flat[i*XLEN +: XLEN];
    endfunction

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        for (int i = 0; i < NREGS; i++) sb_push($sformatf("rst_reg%0d", i), (i == 4) ? 64'd254 : 64'd0);
        sb_push("rst_stall", 0);
        sb_push("rst_claim_ready", 1);
        for (int i = 0; i < NREGS; i++) sb_pop(reg_at(i));
        sb_pop(stall);
        sb_pop(claim_ready);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Same-port collision: M wins
        dstE = 4; valE = 246; dstM = 4; valM = 77;
        sb_push("collide_valA", 77);
        tick();
        idle(); srcA = 4; #1;
        sb_pop(valA);

        // Claim then read
        claim_valid = 1; claim_dstE = 2;
        sb_push("claim_busyA", 1);
        sb_push("claim_stall", 1);
        tick();
        idle(); srcA = 2; #1;
        sb_pop(busyA);
        sb_pop(stall);
        dstE = 2; valE = 9;
`ifdef REGFILE_BYPASS_EN
        sb_push("retire_same_valA", 9);
        sb_push("retire_same_busyA", 0);
`else
        sb_push("retire_same_valA", 0);
        sb_push("retire_same_busyA", 1);
`endif
        #1;
        sb_pop(valA);
        sb_pop(busyA);
        sb_push("retire_next_valA", 9);
        sb_push("retire_next_busyA", 0);
        tick();
        idle(); srcA = 2; #1;
        sb_pop(valA);
        sb_pop(busyA);

        // Saturation on reg 3
        for (int k = 0; k < 3; k++) begin
            idle(); claim_valid = 1; claim_dstE = 3; #1;
            sb_push($sformatf("sat_ready%0d", k), 1);
            sb_pop(claim_ready);
            tick();
        end
        idle(); claim_valid = 1; claim_dstE = 3; claim_dstM = 7; #1;
        sb_push("sat_ready_full", 0);
        sb_push("sat_stall_full", 1);
        sb_pop(claim_ready);
        sb_pop(stall);
        tick();
        idle(); claim_valid = 1; claim_dstE = 3; dstE = 3; valE = 100; #1;
        sb_push("sat_ready_with_retire", 1);
        sb_pop(claim_ready);
        tick();
        idle(); claim_valid = 1; claim_dstE = 3; srcB = 7; #1;
        sb_push("sat_still_full", 0);
        sb_push("sat_rejected_M_busyB", 0);
        sb_pop(claim_ready);
        sb_pop(busyB);
        for (int k = 0; k < 3; k++) begin
            idle(); dstE = 3; valE = 64'(k); tick();
            idle(); srcA = 3; #1;
            sb_push($sformatf("drain_busy%0d", k), (k < 2) ? 1 : 0);
            sb_pop(busyA);
        end

        // Underflow on reg 5
        idle(); dstE = 5; valE = 11; srcA = 5; #1;
        sb_push("uf_busy_same", 0);
        sb_pop(busyA);
        tick();
        idle(); srcA = 5; #1;
        sb_push("uf_valA", 11);
        sb_push("uf_busy_next", 0);
        sb_push("uf_flat5", 11);
        sb_pop(valA);
        sb_pop(busyA);
        sb_pop(reg_at(5));

        // Reset mid-flight on reg 6
        idle(); dstM = 6; valM = 40; tick();
        for (int k = 0; k < 2; k++) begin
            idle(); claim_valid = 1; claim_dstM = 6; tick();
        end
        idle(); srcB = 6; #1;
        sb_push("mid_valB", 40);
        sb_push("mid_busyB", 1);
        sb_pop(valB);
        sb_pop(busyB);
        #1 rst_n = 1'b0;
        #1;
        sb_push("mid_rst_valB", 0);
        sb_push("mid_rst_busyB", 0);
        sb_push("mid_rst_stall", 0);
        sb_push("mid_rst_sp", 254);
        sb_pop(valB);
        sb_pop(busyB);
        sb_pop(stall);
        sb_pop(reg_at(4));
        #1 rst_n = 1'b1;
        dstE = 1; valE = 5;
        tick();
        idle(); srcA = 1; srcB = 6; #1;
        sb_push("post_rst_write", 5);
        sb_push("post_rst_busyB", 0);
        sb_pop(valA);
        sb_pop(busyB);

        if (sb_q.size() != 0) check_val("sb_leftover", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
